// File: rtl/spi_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_monitor
// Description : System-clock SPI bus monitor. Oversamples the SPI lines,
//               captures a frame header, collects paired MOSI/MISO payload
//               words into a first-word-fall-through FIFO, optionally
//               filters on a masked header compare and reports per-frame
//               statistics. HDR_BITS and DATA must both be >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_monitor #(
    parameter int HDR_BITS   = 24,
    parameter int DATA       = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MODE       = 0,
    parameter int FILTER     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scsn,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          miso,
    input  logic [HDR_BITS-1:0]           match_val,
    input  logic [HDR_BITS-1:0]           match_mask,
    input  logic                          clr,
    output logic [HDR_BITS-1:0]           hdr,
    output logic                          hdr_valid,
    output logic                          hdr_match,
    input  logic                          rd,
    output logic [2*DATA-1:0]             rdata,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   usedw,
    output logic                          frame_done,
    output logic [15:0]                   frame_len,
    output logic                          short_frame,
    output logic                          overflow
);

    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_UW      = c_AW + 1;
    localparam int c_CNT_MAX = (HDR_BITS > DATA) ? HDR_BITS : DATA;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);
    localparam bit c_CPOL    = ((MODE >> 1) & 1) != 0;
    localparam bit c_CPHA    = (MODE & 1) != 0;
    // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on falling
    localparam bit c_SAMPLE_RISE = (c_CPOL == c_CPHA);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge history
    // ------------------------------------------------------------------
    logic scsn_s1_q, scsn_s2_q, scsn_h_q;
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic mosi_s1_q, mosi_s2_q;
    logic miso_s1_q, miso_s2_q;
    // Marks when the scsn history FF holds a genuinely sampled value, so a
    // chip select already low at reset release is not mistaken for a new
    // frame start.
    logic [2:0] fill_q;

    // Bring the asynchronous SPI lines into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scsn_s1_q <= 1'b1;
            scsn_s2_q <= 1'b1;
            scsn_h_q  <= 1'b1;
            sclk_s1_q <= c_CPOL;
            sclk_s2_q <= c_CPOL;
            sclk_h_q  <= c_CPOL;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            fill_q    <= 3'b000;
        end else begin
            scsn_s1_q <= scsn;
            scsn_s2_q <= scsn_s1_q;
            scsn_h_q  <= scsn_s2_q;
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
            fill_q    <= {fill_q[1:0], 1'b1};
        end
    end

    logic w_sample, w_scsn_fall, w_scsn_rise;
    assign w_sample    = c_SAMPLE_RISE ? (~sclk_h_q & sclk_s2_q) : (sclk_h_q & ~sclk_s2_q);
    assign w_scsn_fall = fill_q[2] & scsn_h_q & ~scsn_s2_q;
    assign w_scsn_rise = ~scsn_h_q & scsn_s2_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [c_CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [HDR_BITS-1:0]   hdr_sh_q, hdr_sh_d;
    logic [DATA-1:0]       mosi_sh_q, mosi_sh_d;
    logic [DATA-1:0]       miso_sh_q, miso_sh_d;
    logic [HDR_BITS-1:0]   hdr_q, hdr_d;
    logic                  hdr_valid_q, hdr_valid_d;
    logic                  hdr_match_q, hdr_match_d;
    logic [15:0]           frame_len_q, frame_len_d;
    logic                  short_q, short_d;

    logic [HDR_BITS-1:0]   w_hdr_shift;
    logic [DATA-1:0]       w_mosi_shift, w_miso_shift;
    logic                  w_hdr_done;
    logic                  w_push;
    logic [2*DATA-1:0]     w_word;

    assign w_hdr_shift  = {hdr_sh_q[HDR_BITS-2:0], mosi_s2_q};
    assign w_mosi_shift = {mosi_sh_q[DATA-2:0], mosi_s2_q};
    assign w_miso_shift = {miso_sh_q[DATA-2:0], miso_s2_q};

    // FSM and capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            hdr_sh_q    <= '0;
            mosi_sh_q   <= '0;
            miso_sh_q   <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            hdr_match_q <= 1'b0;
            frame_len_q <= '0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            hdr_sh_q    <= hdr_sh_d;
            mosi_sh_q   <= mosi_sh_d;
            miso_sh_q   <= miso_sh_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_match_q <= hdr_match_d;
            frame_len_q <= frame_len_d;
            short_q     <= short_d;
        end
    end

    // Next-state logic; a bit sampled together with scsn rising is taken
    // before the move to DONE
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        hdr_sh_d    = hdr_sh_q;
        mosi_sh_d   = mosi_sh_q;
        miso_sh_d   = miso_sh_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        hdr_match_d = hdr_match_q;
        frame_len_d = frame_len_q;
        short_d     = short_q;
        w_hdr_done  = 1'b0;
        w_push      = 1'b0;
        w_word      = '0;
        case (state_q)
            S_IDLE: begin
                if (w_scsn_fall) begin
                    state_d    = S_HDR;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    short_d    = 1'b0;
                end
            end
            S_HDR: begin
                if (w_sample) begin
                    hdr_sh_d = w_hdr_shift;
                    if (bit_cnt_q == c_CW'(HDR_BITS - 1)) begin
                        w_hdr_done  = 1'b1;
                        hdr_d       = w_hdr_shift;
                        hdr_valid_d = 1'b1;
                        hdr_match_d = ((w_hdr_shift ^ match_val) & match_mask) == '0;
                        bit_cnt_d   = '0;
                        state_d     = S_PAYLOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_CW'(1);
                    end
                end
                if (w_scsn_rise) begin
                    state_d     = S_DONE;
                    short_d     = ~w_hdr_done;
                    frame_len_d = word_cnt_d;
                end
            end
            S_PAYLOAD: begin
                if (w_sample) begin
                    mosi_sh_d = w_mosi_shift;
                    miso_sh_d = w_miso_shift;
                    if (bit_cnt_q == c_CW'(DATA - 1)) begin
                        w_word    = {w_mosi_shift, w_miso_shift};
                        w_push    = (FILTER == 0) || hdr_match_q;
                        bit_cnt_d = '0;
                        if (word_cnt_q != 16'hFFFF) begin
                            word_cnt_d = word_cnt_q + 16'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_CW'(1);
                    end
                end
                if (w_scsn_rise) begin
                    state_d     = S_DONE;
                    frame_len_d = word_cnt_d;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Payload FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [2*DATA-1:0] mem_q [FIFO_DEPTH];
    logic [c_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [c_UW-1:0]   usedw_q, usedw_d;
    logic              overflow_q;
    logic              w_full, w_empty, w_do_rd, w_do_wr, w_drop;

    assign w_full  = (usedw_q == c_UW'(FIFO_DEPTH));
    assign w_empty = (usedw_q == '0);
    assign w_do_rd = rd & ~w_empty;
    assign w_do_wr = w_push & (~w_full | w_do_rd);
    assign w_drop  = w_push & w_full & ~w_do_rd;

    // Occupancy follows the net effect of push and pop
    always_comb begin
        usedw_d = usedw_q;
        if (w_do_wr && !w_do_rd) begin
            usedw_d = usedw_q + c_UW'(1);
        end else if (!w_do_wr && w_do_rd) begin
            usedw_d = usedw_q - c_UW'(1);
        end
    end

    // Pointers, occupancy and sticky overflow; a new drop wins over clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            usedw_q <= usedw_d;
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_do_rd) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            if (w_drop) begin
                overflow_q <= 1'b1;
            end else if (clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Payload storage
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

    assign hdr         = hdr_q;
    assign hdr_valid   = hdr_valid_q;
    assign hdr_match   = hdr_match_q;
    assign rdata       = w_empty ? '0 : mem_q[rd_ptr_q];
    assign empty       = w_empty;
    assign usedw       = usedw_q;
    assign frame_done  = (state_q == S_DONE);
    assign frame_len   = frame_len_q;
    assign short_frame = (state_q == S_DONE) & short_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_monitor
// Description : Self-checking bench for spi_frame_monitor. Instance 0 runs
//               MODE 0 with filtering, instances 1 and 2 run MODE 3 and
//               MODE 1 for the short-frame checks. Expected payload words
//               are queued as frames are driven and popped as the FIFO is
//               read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_monitor;

    localparam int c_HALF = 4;   // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso = 1'b0;
    logic [2:0]  scsn_v = 3'b111;
    logic [2:0]  rd_v = 3'b000;
    logic [2:0]  clr_v = 3'b000;
    logic [23:0] match_val = '0;
    logic [23:0] match_mask = '0;

    logic [23:0] hdr_o [3];
    logic        hv [3];
    logic        hm [3];
    logic [15:0] rdat [3];
    logic        emp [3];
    logic [4:0]  uw [3];
    logic        fd [3];
    logic [15:0] flen [3];
    logic        sf [3];
    logic        ovf [3];

    int hv_cnt [3];
    int fd_cnt [3];
    int sf_cnt [3];
    int sf_alone [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    spi_frame_monitor #(.MODE(0), .FILTER(1)) u_dut0 (
        .clk(clk), .rst(rst), .scsn(scsn_v[0]), .sclk(sclk), .mosi(mosi), .miso(miso),
        .match_val(match_val), .match_mask(match_mask), .clr(clr_v[0]),
        .hdr(hdr_o[0]), .hdr_valid(hv[0]), .hdr_match(hm[0]), .rd(rd_v[0]),
        .rdata(rdat[0]), .empty(emp[0]), .usedw(uw[0]), .frame_done(fd[0]),
        .frame_len(flen[0]), .short_frame(sf[0]), .overflow(ovf[0])
    );

    spi_frame_monitor #(.MODE(3), .FILTER(1)) u_dut3 (
        .clk(clk), .rst(rst), .scsn(scsn_v[1]), .sclk(sclk), .mosi(mosi), .miso(miso),
        .match_val(match_val), .match_mask(match_mask), .clr(clr_v[1]),
        .hdr(hdr_o[1]), .hdr_valid(hv[1]), .hdr_match(hm[1]), .rd(rd_v[1]),
        .rdata(rdat[1]), .empty(emp[1]), .usedw(uw[1]), .frame_done(fd[1]),
        .frame_len(flen[1]), .short_frame(sf[1]), .overflow(ovf[1])
    );

    spi_frame_monitor #(.MODE(1), .FILTER(1)) u_dut1 (
        .clk(clk), .rst(rst), .scsn(scsn_v[2]), .sclk(sclk), .mosi(mosi), .miso(miso),
        .match_val(match_val), .match_mask(match_mask), .clr(clr_v[2]),
        .hdr(hdr_o[2]), .hdr_valid(hv[2]), .hdr_match(hm[2]), .rd(rd_v[2]),
        .rdata(rdat[2]), .empty(emp[2]), .usedw(uw[2]), .frame_done(fd[2]),
        .frame_len(flen[2]), .short_frame(sf[2]), .overflow(ovf[2])
    );

    // Pulse counters for every instance
    initial begin
        for (int k = 0; k < 3; k++) begin
            hv_cnt[k] = 0; fd_cnt[k] = 0; sf_cnt[k] = 0; sf_alone[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (hv[k]) hv_cnt[k]++;
                if (fd[k]) fd_cnt[k]++;
                if (sf[k] && fd[k]) sf_cnt[k]++;
                if (sf[k] && !fd[k]) sf_alone[k]++;
            end
        end
    end

    function automatic int mode_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 1);
    endfunction

    task automatic spi_open(input int d);
        logic [1:0] m;
        m = 2'(mode_of(d));
        sclk = m[1];
        repeat (4) @(negedge clk);
        scsn_v[d] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Sends the low nbits of mo/mi, MSB first, in the given instance's mode
    task automatic spi_bits(input int d, input int nbits, input logic [255:0] mo, input logic [255:0] mi);
        logic [1:0] m;
        int b;
        m = 2'(mode_of(d));
        for (int i = 0; i < nbits; i++) begin
            b = nbits - 1 - i;
            if (!m[0]) begin
                mosi = mo[b]; miso = mi[b];
                repeat (c_HALF) @(negedge clk);
                sclk = ~sclk;
                repeat (c_HALF) @(negedge clk);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = mo[b]; miso = mi[b];
                repeat (c_HALF) @(negedge clk);
                sclk = ~sclk;
                repeat (c_HALF) @(negedge clk);
            end
        end
    endtask

    task automatic spi_close(input int d);
        repeat (c_HALF) @(negedge clk);
        scsn_v[d] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic spi_frame(input int d, input int nbits, input logic [255:0] mo, input logic [255:0] mi);
        spi_open(d);
        spi_bits(d, nbits, mo, mi);
        spi_close(d);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (hdr_o[0] !== 24'h0) begin n_fail++; $display("FAIL reset_hdr got=%h exp=000000", hdr_o[0]); end
        n_checks++; if (emp[0] !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", emp[0]); end
        n_checks++; if ({hv[0], hm[0], fd[0], sf[0], ovf[0]} !== 5'b0) begin n_fail++;
            $display("FAIL reset_flags got=%b exp=00000", {hv[0], hm[0], fd[0], sf[0], ovf[0]}); end
        n_checks++; if ({uw[0], flen[0], rdat[0]} !== 37'h0) begin n_fail++;
            $display("FAIL reset_counts usedw=%0d flen=%0d rdata=%h exp=0", uw[0], flen[0], rdat[0]); end
    endtask

    task automatic test_basic_frame();
        int hv0, fd0, sf0, n;
        hv0 = hv_cnt[0]; fd0 = fd_cnt[0]; sf0 = sf_cnt[0];
        match_val = 24'h0; match_mask = 24'h0;
        exp_q.push_back(16'hAA01);
        exp_q.push_back(16'h5502);
        spi_frame(0, 40, 256'h000F04AA55, 256'h0000000102);
        n_checks++; if (hdr_o[0] !== 24'h000F04) begin n_fail++; $display("FAIL basic_hdr got=%h exp=000f04", hdr_o[0]); end
        n_checks++; if (hv_cnt[0] - hv0 !== 1) begin n_fail++; $display("FAIL basic_hdr_valid got=%0d exp=1", hv_cnt[0] - hv0); end
        n_checks++; if (hm[0] !== 1'b1) begin n_fail++; $display("FAIL basic_match got=%b exp=1", hm[0]); end
        n_checks++; if (uw[0] !== 5'd2) begin n_fail++; $display("FAIL basic_usedw got=%0d exp=2", uw[0]); end
        n_checks++; if (flen[0] !== 16'd2) begin n_fail++; $display("FAIL basic_flen got=%0d exp=2", flen[0]); end
        n_checks++; if (fd_cnt[0] - fd0 !== 1 || sf_cnt[0] - sf0 !== 0) begin n_fail++;
            $display("FAIL basic_done fd=%0d sf=%0d exp=1/0", fd_cnt[0] - fd0, sf_cnt[0] - sf0); end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_checks++; if (emp[0] !== 1'b0 || rdat[0] !== e) begin n_fail++;
                $display("FAIL basic_rdata[%0d] got=%h empty=%b exp=%h", i, rdat[0], emp[0], e); end
            rd_v[0] = 1'b1;
            @(negedge clk);
        end
        rd_v[0] = 1'b0;
        n_checks++; if (emp[0] !== 1'b1 || uw[0] !== 5'd0) begin n_fail++;
            $display("FAIL basic_drained empty=%b usedw=%0d exp=1/0", emp[0], uw[0]); end
    endtask

    task automatic test_filter();
        int fd0;
        fd0 = fd_cnt[0];
        match_val = 24'h001000; match_mask = 24'hFFFF00;
        spi_frame(0, 40, 256'h000F04AA55, 256'h0000000102);
        n_checks++; if (hm[0] !== 1'b0) begin n_fail++; $display("FAIL filter_match got=%b exp=0", hm[0]); end
        n_checks++; if (uw[0] !== 5'd0) begin n_fail++; $display("FAIL filter_usedw got=%0d exp=0", uw[0]); end
        n_checks++; if (flen[0] !== 16'd2) begin n_fail++; $display("FAIL filter_flen got=%0d exp=2", flen[0]); end
        n_checks++; if (fd_cnt[0] - fd0 !== 1) begin n_fail++; $display("FAIL filter_done got=%0d exp=1", fd_cnt[0] - fd0); end
        match_val = 24'h0; match_mask = 24'h0;
    endtask

    task automatic test_short_frame();
        for (int d = 0; d < 3; d++) begin
            int hv0, fd0, sf0, sa0;
            hv0 = hv_cnt[d]; fd0 = fd_cnt[d]; sf0 = sf_cnt[d]; sa0 = sf_alone[d];
            spi_frame(d, 10, 256'h2A5, 256'h155);
            n_checks++; if (hv_cnt[d] - hv0 !== 0) begin n_fail++;
                $display("FAIL short_hdr_valid mode=%0d got=%0d exp=0", mode_of(d), hv_cnt[d] - hv0); end
            n_checks++; if (fd_cnt[d] - fd0 !== 1 || sf_cnt[d] - sf0 !== 1 || sf_alone[d] - sa0 !== 0) begin n_fail++;
                $display("FAIL short_pulses mode=%0d fd=%0d sf=%0d lone_sf=%0d exp=1/1/0", mode_of(d),
                         fd_cnt[d] - fd0, sf_cnt[d] - sf0, sf_alone[d] - sa0); end
            n_checks++; if (flen[d] !== 16'd0) begin n_fail++;
                $display("FAIL short_flen mode=%0d got=%0d exp=0", mode_of(d), flen[d]); end
        end
    endtask

    task automatic test_overflow();
        logic [255:0] mo, mi;
        mo = 256'h000F04; mi = '0;
        for (int i = 0; i < 20; i++) begin
            mo = (mo << 8) | 256'(i);
            mi = (mi << 8) | 256'(8'hF0 ^ 8'(i));
            if (i < 16) exp_q.push_back({8'(i), 8'hF0 ^ 8'(i)});
        end
        spi_frame(0, 24 + 160, mo, mi);
        n_checks++; if (uw[0] !== 5'd16) begin n_fail++; $display("FAIL ovf_usedw got=%0d exp=16", uw[0]); end
        n_checks++; if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", ovf[0]); end
        n_checks++; if (flen[0] !== 16'd20) begin n_fail++; $display("FAIL ovf_flen got=%0d exp=20", flen[0]); end
        rd_v[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_checks++; if (emp[0] !== 1'b0 || rdat[0] !== e) begin n_fail++;
                $display("FAIL ovf_rdata[%0d] got=%h empty=%b exp=%h", i, rdat[0], emp[0], e); end
            @(negedge clk);
        end
        // rd still held here: a pop on an empty FIFO must be ignored
        @(negedge clk);
        rd_v[0] = 1'b0;
        n_checks++; if (emp[0] !== 1'b1 || uw[0] !== 5'd0) begin n_fail++;
            $display("FAIL ovf_drained empty=%b usedw=%0d exp=1/0", emp[0], uw[0]); end
        n_checks++; if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ovf[0]); end
        clr_v[0] = 1'b1;
        @(negedge clk);
        clr_v[0] = 1'b0;
        n_checks++; if (ovf[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", ovf[0]); end
    endtask

    task automatic test_partial_word();
        exp_q.push_back(16'h3CC3);
        spi_frame(0, 37, {219'h0, 24'h000F04, 8'h3C, 5'b10101}, {219'h0, 24'h0, 8'hC3, 5'b01010});
        n_checks++; if (flen[0] !== 16'd1) begin n_fail++; $display("FAIL partial_flen got=%0d exp=1", flen[0]); end
        n_checks++; if (uw[0] !== 5'd1) begin n_fail++; $display("FAIL partial_usedw got=%0d exp=1", uw[0]); end
        begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_checks++; if (rdat[0] !== e) begin n_fail++; $display("FAIL partial_rdata got=%h exp=%h", rdat[0], e); end
        end
        rd_v[0] = 1'b1;
        @(negedge clk);
        rd_v[0] = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int hv0, fd0;
        spi_open(0);
        spi_bits(0, 12, 256'h000, 256'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        hv0 = hv_cnt[0]; fd0 = fd_cnt[0];
        n_checks++; if ({hdr_o[0], hm[0], ovf[0], uw[0], flen[0]} !== 47'h0 || emp[0] !== 1'b1) begin n_fail++;
            $display("FAIL midrst_state hdr=%h match=%b ovf=%b usedw=%0d flen=%0d empty=%b exp=reset values",
                     hdr_o[0], hm[0], ovf[0], uw[0], flen[0], emp[0]); end
        spi_bits(0, 28, 256'hF04AA55, 256'h0000102);
        spi_close(0);
        n_checks++; if (hv_cnt[0] - hv0 !== 0 || fd_cnt[0] - fd0 !== 0) begin n_fail++;
            $display("FAIL midrst_capture hv=%0d fd=%0d exp=0/0", hv_cnt[0] - hv0, fd_cnt[0] - fd0); end
        n_checks++; if (uw[0] !== 5'd0 || hdr_o[0] !== 24'h0) begin n_fail++;
            $display("FAIL midrst_fifo usedw=%0d hdr=%h exp=0/000000", uw[0], hdr_o[0]); end
    endtask

    task automatic test_back_to_back();
        int hv0, fd0, n;
        hv0 = hv_cnt[0]; fd0 = fd_cnt[0];
        exp_q.push_back(16'h1122); exp_q.push_back(16'h3344);
        spi_frame(0, 40, 256'h0102031133, 256'h0000002244);
        exp_q.push_back(16'h55AA); exp_q.push_back(16'h66BB); exp_q.push_back(16'h77CC);
        spi_frame(0, 48, 256'hABCDEF556677, 256'h000000AABBCC);
        n_checks++; if (hv_cnt[0] - hv0 !== 2 || fd_cnt[0] - fd0 !== 2) begin n_fail++;
            $display("FAIL b2b_pulses hv=%0d fd=%0d exp=2/2", hv_cnt[0] - hv0, fd_cnt[0] - fd0); end
        n_checks++; if (hdr_o[0] !== 24'hABCDEF || flen[0] !== 16'd3) begin n_fail++;
            $display("FAIL b2b_last hdr=%h flen=%0d exp=abcdef/3", hdr_o[0], flen[0]); end
        n_checks++; if (uw[0] !== 5'd5) begin n_fail++; $display("FAIL b2b_usedw got=%0d exp=5", uw[0]); end
        n = exp_q.size();
        rd_v[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_checks++; if (emp[0] !== 1'b0 || rdat[0] !== e) begin n_fail++;
                $display("FAIL b2b_rdata[%0d] got=%h empty=%b exp=%h", i, rdat[0], emp[0], e); end
            @(negedge clk);
        end
        rd_v[0] = 1'b0;
        n_checks++; if (emp[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_drained empty=%b exp=1", emp[0]); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_filter();
        test_short_frame();
        test_overflow();
        test_partial_word();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
